// File: rtl/uop_decode.sv
// uop_decode: RV32 ADD/ADDI decoder behind a two-entry output/skid buffer.
// Define UOP_DECODE_PERF_EN to add the perf_decoded/perf_illegal counters.
package UOP;
  typedef enum logic [1:0] {
    EX_NONE   = 2'd0,
    EX_DECODE = 2'd1,
    EX_MEM    = 2'd2
  } ex_t;

  typedef enum logic [6:0] {
    OP_ADD  = 7'd0,
    OP_ADDI = 7'd1
  } op_t;

  typedef struct packed {
    ex_t         ex;
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } dec_t;
endpackage

module uop_decode
  import UOP::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [1:0]  in_ex,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef UOP_DECODE_PERF_EN
  output logic [31:0] perf_decoded,
  output logic [31:0] perf_illegal,
`endif
  output logic [55:0] out_uop
);

  dec_t dec;
  dec_t out_q;
  dec_t skid_q;
  logic out_v;
  logic skid_v;
  logic accept;
  logic load;
  logic is_mem;
  logic is_add;
  logic is_addi;

  assign in_ready  = !skid_v;
  assign out_valid = out_v;
  assign out_uop   = out_q;
  assign accept    = in_valid && !skid_v && !flush;
  assign load      = !out_v || out_ready;

  assign is_mem  = (in_ex == EX_MEM);
  assign is_add  = !is_mem
                && (in_instr[6:0] == 7'b0110011)
                && (in_instr[14:12] == 3'b000)
                && (in_instr[31:25] == 7'b0000000);
  assign is_addi = !is_mem
                && (in_instr[6:0] == 7'b0010011)
                && (in_instr[14:12] == 3'b000);

  // Decode the offered word; a fetch fault overrides any decode result.
  always_comb begin
    dec = '0;
    unique case (1'b1)
      is_mem: begin
        dec.ex = EX_MEM;
      end
      is_add: begin
        dec.op  = OP_ADD;
        dec.rd  = in_instr[11:7];
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
      end
      is_addi: begin
        dec.op  = OP_ADDI;
        dec.rd  = in_instr[11:7];
        dec.rs1 = in_instr[19:15];
        dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      default: begin
        dec.ex  = EX_DECODE;
        dec.imm = in_instr;
      end
    endcase
  end

  // Output register refills from skid first, else from the decoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (load) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        out_v <= accept;
        if (accept) out_q <= dec;
      end
    end else if (accept) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

`ifdef UOP_DECODE_PERF_EN
  // Count every accepted word and the accepted illegal ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_decoded <= '0;
      perf_illegal <= '0;
    end else if (accept) begin
      perf_decoded <= perf_decoded + 32'd1;
      if (dec.ex == EX_DECODE)
        perf_illegal <= perf_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uop_decode.sv
// tb_uop_decode: directed and random checks of uop_decode
// against a queue-based reference model.
module tb_uop_decode;
  import UOP::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [1:0]  in_ex;
  logic        out_valid;
  logic        out_ready;
  logic [55:0] out_uop;
  logic [31:0] perf_decoded;
  logic [31:0] perf_illegal;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  dec_t q[$];
  logic [31:0] m_dec = '0;
  logic [31:0] m_ill = '0;

  always #5 clk = ~clk;

  uop_decode dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_instr(in_instr),
    .in_ex(in_ex),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef UOP_DECODE_PERF_EN
    .perf_decoded(perf_decoded),
    .perf_illegal(perf_illegal),
`endif
    .out_uop(out_uop)
  );

`ifndef UOP_DECODE_PERF_EN
  assign perf_decoded = '0;
  assign perf_illegal = '0;
`endif

  function automatic dec_t ref_dec(input logic [31:0] w,
                                   input logic [1:0] ex);
    dec_t r;
    r = '0;
    if (ex == EX_MEM) begin
      r.ex = EX_MEM;
    end else if (w[6:0] == 7'h33 && w[14:12] == 3'd0
                 && w[31:25] == 7'd0) begin
      r.op  = OP_ADD;
      r.rd  = w[11:7];
      r.rs1 = w[19:15];
      r.rs2 = w[24:20];
    end else if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin
      r.op  = OP_ADDI;
      r.rd  = w[11:7];
      r.rs1 = w[19:15];
      r.imm = 32'($signed(w) >>> 20);
    end else begin
      r.ex  = EX_DECODE;
      r.imm = w;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Compare DUT with the model, then advance both one clock.
  task automatic step();
    dec_t r;
    bit acc;
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) chk("out_uop", 64'(out_uop), 64'(q[0]));
`ifdef UOP_DECODE_PERF_EN
      chk("perf_decoded", 64'(perf_decoded), 64'(m_dec));
      chk("perf_illegal", 64'(perf_illegal), 64'(m_ill));
`endif
    end
    r = ref_dec(in_instr, in_ex);
    acc = in_valid && (q.size() < 2) && !flush;
    if (rst) begin
      q.delete();
      m_dec = '0;
      m_ill = '0;
    end else begin
      if (acc) begin
        m_dec = m_dec + 32'd1;
        if (r.ex == EX_DECODE) m_ill = m_ill + 32'd1;
      end
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (flush) q.delete();
      else if (acc) q.push_back(r);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk_addi(input logic [11:0] imm,
                                          input logic [4:0] rd);
    return {imm, 5'd1, 3'd0, rd, 7'h13};
  endfunction

  task automatic drive(input logic [31:0] w, input logic [1:0] ex);
    in_valid = 1'b1;
    in_instr = w;
    in_ex    = ex;
  endtask

  dec_t e;
  dec_t o;
  logic [31:0] ill0;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_instr = '0; in_ex = EX_NONE; out_ready = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_uop", 64'(out_uop), 64'd0);

    // ADD x3,x1,x2
    out_ready = 1'b1;
    drive(32'h002081B3, EX_NONE);
    step();
    in_valid = 1'b0;
    e = '0; e.ex = EX_NONE; e.op = OP_ADD;
    e.rd = 5'd3; e.rs1 = 5'd1; e.rs2 = 5'd2; e.imm = 32'd0;
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_uop", 64'(out_uop), 64'(e));
    step();

    // ADDI negative and positive immediates
    drive(32'hFFF30293, EX_NONE);
    step();
    o = out_uop;
    chk("addi_op", 64'(o.op), 64'(OP_ADDI));
    chk("addi_rd", 64'(o.rd), 64'd5);
    chk("addi_rs1", 64'(o.rs1), 64'd6);
    chk("addi_rs2", 64'(o.rs2), 64'd0);
    chk("addi_imm_neg", 64'(o.imm), 64'hFFFFFFFF);
    drive(32'h7FF30293, EX_NONE);
    step();
    in_valid = 1'b0;
    o = out_uop;
    chk("addi_imm_pos", 64'(o.imm), 64'h000007FF);
    step();

    // illegal word, then same word with a fetch fault
    ill0 = perf_illegal;
    drive(32'hFFFFFFFF, EX_NONE);
    step();
    o = out_uop;
    chk("ill_ex", 64'(o.ex), 64'(EX_DECODE));
    chk("ill_imm", 64'(o.imm), 64'hFFFFFFFF);
    drive(32'hFFFFFFFF, EX_MEM);
    step();
    in_valid = 1'b0;
    o = out_uop;
    chk("mem_ex", 64'(o.ex), 64'(EX_MEM));
    chk("mem_imm", 64'(o.imm), 64'd0);
    step();
`ifdef UOP_DECODE_PERF_EN
    chk("perf_ill_inc", 64'(perf_illegal), 64'(ill0 + 32'd1));
`endif

    // stall: stream A,B,C with out_ready low
    out_ready = 1'b0;
    drive(mk_addi(12'd1, 5'd10), EX_NONE);
    step();
    drive(mk_addi(12'd2, 5'd11), EX_NONE);
    step();
    drive(mk_addi(12'd3, 5'd12), EX_NONE);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    step();
    step();
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    step();
    step();
    step();

    // flush with both entries full and a word offered
    out_ready = 1'b0;
    drive(mk_addi(12'd4, 5'd13), EX_NONE);
    step();
    drive(mk_addi(12'd5, 5'd14), EX_NONE);
    step();
    drive(mk_addi(12'd6, 5'd15), EX_NONE);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    step();

    // reset while stalled full
    out_ready = 1'b0;
    drive(mk_addi(12'd7, 5'd16), EX_NONE);
    step();
    drive(32'h0000000F, EX_NONE);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
`ifdef UOP_DECODE_PERF_EN
    chk("rst2_perf_dec", 64'(perf_decoded), 64'd0);
    chk("rst2_perf_ill", 64'(perf_illegal), 64'd0);
`endif
    step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] a, b, c;
      logic [11:0] im;
      a  = 5'($urandom);
      b  = 5'($urandom);
      c  = 5'($urandom);
      im = 12'($urandom);
      case ($urandom_range(0, 3))
        0: in_instr = {7'd0, b, a, 3'd0, c, 7'h33};
        1: in_instr = {im, a, 3'd0, c, 7'h13};
        2: in_instr = {7'h20, b, a, 3'd0, c, 7'h33};
        default: in_instr = $urandom;
      endcase
      in_ex     = ($urandom_range(0, 9) == 0) ? EX_MEM : EX_NONE;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
